// File: rtl/sweep_generator.sv
// Linear-FM (chirp) DDFS core: sweeps the FTW between start/stop and accumulates phase per sample.
// Optional macro SWEEP_PHASE_RESET_EN: every accepted start clears the phase accumulator to 0.
module sweep_generator #(
    parameter int unsigned SYS_CLK_HZ = 50000000,
    parameter int unsigned SAMPLE_HZ  = 96000,
    parameter int unsigned STEP_HZ    = 200,
    parameter int unsigned FTW_W      = 16,
    parameter int unsigned PHASE_W    = 16,
    parameter int unsigned ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic [FTW_W-1:0]  ftw_start,
    input  logic [FTW_W-1:0]  ftw_stop,
    input  logic [FTW_W-1:0]  ftw_step,
    output logic              busy,
    output logic              done,
    output logic              direction,
    output logic [FTW_W-1:0]  q_ftw,
    output logic [ADDR_W-1:0] q_lut_address,
    output logic              sample_valid
);

    localparam int unsigned SAMPLE_DIV = SYS_CLK_HZ / SAMPLE_HZ;
    localparam int unsigned STEP_DIV   = SYS_CLK_HZ / STEP_HZ;
    localparam int unsigned SAMP_CW    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned STEP_CW    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    localparam logic [SAMP_CW-1:0] SAMP_LAST = SAMP_CW'(SAMPLE_DIV - 1);
    localparam logic [STEP_CW-1:0] STEP_LAST = STEP_CW'(STEP_DIV - 1);

    localparam logic [1:0] MODE_SAW = 2'd1;
    localparam logic [1:0] MODE_TRI = 2'd2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StUp   = 2'd1,
        StDown = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [1:0]           mode_q, mode_d;
    logic [FTW_W-1:0]     start_l_q, start_l_d;
    logic [FTW_W-1:0]     stop_l_q, stop_l_d;
    logic [FTW_W-1:0]     step_l_q, step_l_d;
    logic [FTW_W-1:0]     ftw_q, ftw_d;
    logic                 done_q, done_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 valid_q, valid_d;
    logic [SAMP_CW-1:0]   samp_cnt_q, samp_cnt_d;
    logic [STEP_CW-1:0]   step_cnt_q, step_cnt_d;

    logic                 sweeping;
    logic                 start_acc;
    logic                 samp_tick;
    logic                 step_tick;
    logic [FTW_W:0]       ftw_sum;
    logic [FTW_W:0]       ftw_diff;
    logic [FTW_W-1:0]     ftw_up;
    logic [FTW_W-1:0]     ftw_down;

    assign sweeping  = (state_q != StIdle);
    assign start_acc = start && !sweeping;

    // Dividers: sample tick is free-running, step tick is phase-locked to the accepted start.
    always_comb begin
        samp_tick  = (samp_cnt_q == SAMP_LAST);
        samp_cnt_d = samp_tick ? '0 : samp_cnt_q + SAMP_CW'(1);

        step_tick  = sweeping && (step_cnt_q == STEP_LAST);
        step_cnt_d = step_cnt_q;
        if (start_acc) begin
            step_cnt_d = '0;
        end else if (sweeping) begin
            step_cnt_d = step_tick ? '0 : step_cnt_q + STEP_CW'(1);
        end
    end

    // One extra bit keeps the clamped step free of wrap and underflow.
    always_comb begin
        ftw_sum  = {1'b0, ftw_q} + {1'b0, step_l_q};
        ftw_diff = {1'b0, ftw_q} - {1'b0, step_l_q};
        ftw_up   = (ftw_sum > {1'b0, stop_l_q}) ? stop_l_q : ftw_sum[FTW_W-1:0];
        ftw_down = (ftw_diff[FTW_W] || (ftw_diff[FTW_W-1:0] < start_l_q)) ? start_l_q
                                                                          : ftw_diff[FTW_W-1:0];
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        start_l_d = start_l_q;
        stop_l_d  = stop_l_q;
        step_l_d  = step_l_q;
        ftw_d     = ftw_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d    = mode;
                    start_l_d = ftw_start;
                    stop_l_d  = ftw_stop;
                    step_l_d  = ftw_step;
                    ftw_d     = ftw_start;
                    state_d   = StUp;
                end
            end
            StUp: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (step_tick) begin
                    if (ftw_q >= stop_l_q) begin
                        if (mode_q == MODE_SAW) begin
                            ftw_d = start_l_q;
                        end else if (mode_q == MODE_TRI) begin
                            state_d = StDown;
                        end else begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end
                    end else begin
                        ftw_d = ftw_up;
                    end
                end
            end
            StDown: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (step_tick) begin
                    if (ftw_q <= start_l_q) begin
                        state_d = StUp;
                    end else begin
                        ftw_d = ftw_down;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // A sample tick coinciding with a step tick still sees the pre-step FTW held in ftw_q.
    always_comb begin
        phase_d = phase_q;
        addr_d  = addr_q;
        valid_d = 1'b0;
        if (sweeping && samp_tick) begin
            phase_d = phase_q + PHASE_W'(ftw_q);
            addr_d  = phase_d[PHASE_W-1 -: ADDR_W];
            valid_d = 1'b1;
        end
`ifdef SWEEP_PHASE_RESET_EN
        if (start_acc) begin
            phase_d = '0;
            addr_d  = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            mode_q     <= '0;
            start_l_q  <= '0;
            stop_l_q   <= '0;
            step_l_q   <= '0;
            ftw_q      <= '0;
            done_q     <= 1'b0;
            phase_q    <= '0;
            addr_q     <= '0;
            valid_q    <= 1'b0;
            samp_cnt_q <= '0;
            step_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            start_l_q  <= start_l_d;
            stop_l_q   <= stop_l_d;
            step_l_q   <= step_l_d;
            ftw_q      <= ftw_d;
            done_q     <= done_d;
            phase_q    <= phase_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            samp_cnt_q <= samp_cnt_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    assign busy          = sweeping;
    assign direction     = (state_q == StDown);
    assign done          = done_q;
    assign q_ftw         = ftw_q;
    assign q_lut_address = addr_q;
    assign sample_valid  = valid_q;

endmodule
